sfq_toggle_rx: RTL and testbench

Clocked receiver for the toggle-encoded SFQ pulse convention used in our JTL/gate timing models, where every level change on a line is one SFQ pulse. The block sits at the output end of a pulse path such as a JTL delay chain. It synchronises the pulse line into the digital clock domain and counts pulses. It also measures launch-to-arrival delay in clock cycles after an arm strobe and hands each result to a consumer over a valid/ready interface.

---
 rtl/sfq_rx_pkg.sv | 8 +
 rtl/sfq_toggle_sync.sv | 24 ++
 rtl/sfq_toggle_rx.sv | 68 ++++++
 tb/tb_sfq_toggle_rx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sfq_rx_pkg.sv
// sfq_rx_pkg: shared state encoding and default parameters for the SFQ toggle receiver
package sfq_rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;
  localparam int SYNC_STAGES_D = 2;
  localparam int CNT_W_D = 16;
  localparam int DLY_W_D = 8;
  localparam int TIMEOUT_D = 255;
endpackage

// File: rtl/sfq_toggle_sync.sv
// sfq_toggle_sync: synchronise a toggle-encoded pulse line and flag each level change for one cycle
module sfq_toggle_sync
  import sfq_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D
) (
  input  logic clk,
  input  logic rst,
  input  logic pulse_in,
  output logic pulse_evt
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  // flop chain into the clock domain, then remember the last synchronised level
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pulse_in};
      prev <= sync[SYNC_STAGES-1];
    end
  assign pulse_evt = sync[SYNC_STAGES-1] ^ prev;
endmodule

// File: rtl/sfq_toggle_rx.sv
// sfq_toggle_rx: count SFQ toggle pulses and measure arm-to-arrival delay with valid/ready output
module sfq_toggle_rx
  import sfq_rx_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_D,
  parameter int CNT_W = CNT_W_D,
  parameter int DLY_W = DLY_W_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             arm,
  input  logic             clr_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DLY_W-1:0] m_delay,
  output logic             m_timeout,
  output logic [CNT_W-1:0] pulse_count,
  output logic             spurious,
  output logic             busy
);
  state_t state, state_nx;
  logic [DLY_W-1:0] cnt, cnt_inc;
  logic evt, expire;
  sfq_toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .pulse_in(pulse_in),
    .pulse_evt(evt)
  );
  assign cnt_inc = cnt + 1'b1;
  assign expire = cnt_inc == DLY_W'(TIMEOUT);
  assign m_valid = state == HOLD;
  assign busy = state != IDLE;
  // next state: arrival wins over timeout on the last waiting edge
  always_comb begin
    state_nx = IDLE;
    unique case (state)
      IDLE: state_nx = arm ? WAIT : IDLE;
      WAIT: state_nx = (evt || expire) ? HOLD : WAIT;
      HOLD: state_nx = m_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // cycle counter, captured result, pulse counter and sticky spurious flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      m_delay <= '0;
      m_timeout <= 1'b0;
      pulse_count <= '0;
      spurious <= 1'b0;
    end else begin
      pulse_count <= pulse_count + CNT_W'(evt);
      spurious <= (evt && state != WAIT) || (spurious && !clr_err);
      if (state == IDLE && arm) cnt <= '0;
      if (state == WAIT) cnt <= cnt_inc;
      if (state == WAIT && (evt || expire)) begin
        m_delay <= cnt_inc;
        m_timeout <= !evt;
      end
    end
endmodule

// File: tb/tb_sfq_toggle_rx.sv
// tb_sfq_toggle_rx: scenario tasks with a result scoreboard for the SFQ toggle receiver
module tb_sfq_toggle_rx;
  logic clk = 1'b0, rst = 1'b1, pulse_in = 1'b0, arm = 1'b0, clr_err = 1'b0, m_ready = 1'b0;
  logic m_valid, m_timeout, spurious, busy;
  logic [7:0] m_delay;
  logic [3:0] pulse_count;
  int checks = 0, failures = 0;
  logic [3:0] exp_count = '0;
  typedef struct packed {logic [7:0] d; logic t;} res_t;
  res_t q[$];
  res_t r;

  sfq_toggle_rx #(.SYNC_STAGES(2), .CNT_W(4), .DLY_W(8), .TIMEOUT(255)) dut (
    .clk(clk),
    .rst(rst),
    .pulse_in(pulse_in),
    .arm(arm),
    .clr_err(clr_err),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_delay(m_delay),
    .m_timeout(m_timeout),
    .pulse_count(pulse_count),
    .spurious(spurious),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(negedge clk);
  endtask

  task automatic toggle;
    pulse_in = ~pulse_in;
    exp_count++;
  endtask

  task automatic test_reset;
    repeat (2) step;
    checks++;
    if ({m_valid, m_delay, m_timeout, pulse_count, spurious, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required all zero", {m_valid, m_delay, m_timeout, pulse_count, spurious, busy});
    end
    rst = 1'b0;
    step;
  endtask

  task automatic test_basic;
    arm = 1'b1;
    q.push_back(res_t'{8'd7, 1'b0});
    step;
    arm = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b required 1", busy); end
    repeat (4) step;
    toggle;
    repeat (2) step;
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %b required 0", m_valid); end
    step;
    checks++;
    if (m_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %b required 1", m_valid); end
    r = q.pop_front();
    checks++;
    if (m_delay !== r.d) begin failures++; $display("FAIL basic_delay: got %0d required %0d", m_delay, r.d); end
    checks++;
    if (m_timeout !== r.t) begin failures++; $display("FAIL basic_timeout: got %b required %b", m_timeout, r.t); end
    checks++;
    if (pulse_count !== exp_count) begin failures++; $display("FAIL basic_count: got %0d required %0d", pulse_count, exp_count); end
    checks++;
    if (spurious !== 1'b0) begin failures++; $display("FAIL basic_spurious: got %b required 0", spurious); end
    m_ready = 1'b1;
    step;
    m_ready = 1'b0;
    checks++;
    if ({busy, m_valid} !== 2'b00) begin failures++; $display("FAIL basic_release: got %b required 00", {busy, m_valid}); end
  endtask

  task automatic test_timeout;
    arm = 1'b1;
    q.push_back(res_t'{8'd255, 1'b1});
    step;
    arm = 1'b0;
    repeat (254) step;
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL timeout_early_valid: got %b required 0", m_valid); end
    step;
    checks++;
    if (m_valid !== 1'b1) begin failures++; $display("FAIL timeout_valid: got %b required 1", m_valid); end
    r = q.pop_front();
    checks++;
    if ({m_delay, m_timeout} !== {r.d, r.t}) begin failures++; $display("FAIL timeout_result: got %0d/%b required %0d/%b", m_delay, m_timeout, r.d, r.t); end
    repeat (10) step;
    checks++;
    if ({m_valid, m_delay, m_timeout} !== {1'b1, r.d, r.t}) begin failures++; $display("FAIL timeout_hold: got %b/%0d/%b required 1/%0d/%b", m_valid, m_delay, m_timeout, r.d, r.t); end
    m_ready = 1'b1;
    step;
    m_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL timeout_release: got %b required 0", busy); end
  endtask

  task automatic test_spurious;
    toggle;
    repeat (5) step;
    toggle;
    repeat (4) step;
    checks++;
    if (pulse_count !== exp_count) begin failures++; $display("FAIL spur_count: got %0d required %0d", pulse_count, exp_count); end
    checks++;
    if (spurious !== 1'b1) begin failures++; $display("FAIL spur_set: got %b required 1", spurious); end
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    checks++;
    if (spurious !== 1'b0) begin failures++; $display("FAIL spur_clear: got %b required 0", spurious); end
    toggle;
    repeat (2) step;
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    checks++;
    if (spurious !== 1'b1) begin failures++; $display("FAIL spur_set_wins: got %b required 1", spurious); end
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
    checks++;
    if (spurious !== 1'b0) begin failures++; $display("FAIL spur_clear2: got %b required 0", spurious); end
  endtask

  task automatic test_simultaneous;
    toggle;
    repeat (2) step;
    arm = 1'b1;
    q.push_back(res_t'{8'd255, 1'b0});
    step;
    arm = 1'b0;
    checks++;
    if ({busy, spurious} !== 2'b11) begin failures++; $display("FAIL simul_busy_spur: got %b required 11", {busy, spurious}); end
    repeat (252) step;
    toggle;
    repeat (2) step;
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL simul_early_valid: got %b required 0", m_valid); end
    step;
    checks++;
    if (m_valid !== 1'b1) begin failures++; $display("FAIL simul_valid: got %b required 1", m_valid); end
    r = q.pop_front();
    checks++;
    if ({m_delay, m_timeout} !== {r.d, r.t}) begin failures++; $display("FAIL simul_last_edge: got %0d/%b required %0d/%b", m_delay, m_timeout, r.d, r.t); end
    checks++;
    if (pulse_count !== exp_count) begin failures++; $display("FAIL simul_count: got %0d required %0d", pulse_count, exp_count); end
    m_ready = 1'b1;
    arm = 1'b1;
    step;
    m_ready = 1'b0;
    arm = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL simul_arm_ignored: got %b required 0", busy); end
    clr_err = 1'b1;
    step;
    clr_err = 1'b0;
  endtask

  task automatic test_wrap_reset;
    logic seen;
    rst = 1'b1;
    pulse_in = 1'b0;
    exp_count = '0;
    step;
    rst = 1'b0;
    step;
    for (int i = 0; i < 17; i++) begin
      toggle;
      repeat (3) step;
    end
    checks++;
    if (pulse_count !== exp_count) begin failures++; $display("FAIL wrap_count: got %0d required %0d", pulse_count, exp_count); end
    arm = 1'b1;
    q.push_back(res_t'{8'd0, 1'b0});
    step;
    arm = 1'b0;
    repeat (3) step;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL wrap_busy: got %b required 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m_valid, m_delay, m_timeout, pulse_count, spurious, busy} !== '0) begin
      failures++;
      $display("FAIL async_reset: got %b required all zero", {m_valid, m_delay, m_timeout, pulse_count, spurious, busy});
    end
    q.delete();
    exp_count = '0;
    pulse_in = 1'b0;
    step;
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      step;
      seen |= m_valid | busy;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL reset_no_result: got %b required 0", seen); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_timeout;
    test_spurious;
    test_simultaneous;
    test_wrap_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
